// File: rtl/se_sram_tdp_be_pkg.sv
// Shared definitions for the byte-enabled true-dual-port SRAM: init FSM states,
// legal read latencies and lane-count helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package se_sram_tdp_be_pkg;

   // Post-reset clear sweep controller states
   typedef enum logic [0:0] {
      INIT_IDLE  = 1'b0,
      INIT_CLEAR = 1'b1
   } init_state_e;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   function automatic bit read_latency_legal(input int lat);
      return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
   endfunction

   function automatic int be_width(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/se_sram_lane_merge.sv
// Per-lane word merge: each lane comes from new_i where be_i is set, otherwise from old_i.
// Latency: combinational. Backpressure: none.
// Ports: old_i (current word), new_i (incoming word), be_i (lane enables), word_o (merged word).
module se_sram_lane_merge #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int BE_W   = DATA_W / BYTE_W
) (
   input  logic [DATA_W-1:0] old_i,
   input  logic [DATA_W-1:0] new_i,
   input  logic [BE_W-1:0]   be_i,
   output logic [DATA_W-1:0] word_o
);

   always_comb begin
      word_o = old_i;
      for (int k = 0; k < BE_W; k++) begin
         if (be_i[k]) begin
            word_o[k*BYTE_W +: BYTE_W] = new_i[k*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/se_sram_tdp_be.sv
// Single-clock true-dual-port SRAM, byte enables on both ports, defined same-address collisions.
// Latency: READ_LATENCY (1 or 2) enabled cycles from accepted read to data_out_N/data_valid_N.
// Backpressure: none on requests; sram_clock__enable low stalls everything, init_busy drops requests.
// Ports: sram_clock/sram_reset (sync, active-high)/sram_clock__enable; per port N in {0,1}:
//   select_N, read_not_write_N, byte_enable_N, address_N, write_data_N in; data_out_N, data_valid_N out;
//   init_busy out while the post-reset clear sweep runs.
module se_sram_tdp_be
   import se_sram_tdp_be_pkg::*;
#(
   parameter int    ADDR_W         = 14,
   parameter int    DATA_W         = 32,
   parameter int    BYTE_W         = 8,
   parameter int    READ_LATENCY   = 1,
   parameter bit    CLEAR_ON_RESET = 1'b0,
   parameter string INITFILE       = ""
) (
   input  logic                     sram_clock,
   input  logic                     sram_reset,
   input  logic                     sram_clock__enable,
   input  logic                     select_0,
   input  logic                     read_not_write_0,
   input  logic [DATA_W/BYTE_W-1:0] byte_enable_0,
   input  logic [ADDR_W-1:0]        address_0,
   input  logic [DATA_W-1:0]        write_data_0,
   output logic [DATA_W-1:0]        data_out_0,
   output logic                     data_valid_0,
   input  logic                     select_1,
   input  logic                     read_not_write_1,
   input  logic [DATA_W/BYTE_W-1:0] byte_enable_1,
   input  logic [ADDR_W-1:0]        address_1,
   input  logic [DATA_W-1:0]        write_data_1,
   output logic [DATA_W-1:0]        data_out_1,
   output logic                     data_valid_1,
   output logic                     init_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int BE_W  = be_width(DATA_W, BYTE_W);

   if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
      $error("se_sram_tdp_be: DATA_W must be a multiple of BYTE_W");
   end
   if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $error("se_sram_tdp_be: READ_LATENCY must be 1 or 2");
   end
   if (CLEAR_ON_RESET && (INITFILE != "")) begin : g_clear_vs_image
      $warning("se_sram_tdp_be: CLEAR_ON_RESET zeroes the INITFILE image after every reset");
   end

   (* ram_init_file = INITFILE *) logic [DATA_W-1:0] mem_q [DEPTH];

   init_state_e       state_q;
   logic [ADDR_W-1:0] clr_addr_q;
   logic              busy_q;

   // Requests presented in a reset cycle are dropped so a restart never
   // races a stray write into the array.
   logic accept_ok;
   logic wr0, wr1, rd0, rd1, same_addr, clear_we;
   logic [DATA_W-1:0] old0, old1, wword0, wword1, base0, rdata1;

   assign accept_ok = sram_clock__enable && !busy_q && !sram_reset;
   assign wr0       = accept_ok && select_0 && !read_not_write_0;
   assign wr1       = accept_ok && select_1 && !read_not_write_1;
   assign rd0       = accept_ok && select_0 && read_not_write_0;
   assign rd1       = accept_ok && select_1 && read_not_write_1;
   assign same_addr = (address_0 == address_1);
   assign clear_we  = sram_clock__enable && !sram_reset && busy_q;

   assign old0 = mem_q[address_0];
   assign old1 = mem_q[address_1];

   // Port 1 merges first; port 0 then merges on top of that result when both
   // hit the same word, so port 0 owns any lane both ports enable.
   se_sram_lane_merge #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .BE_W(BE_W)) u_merge1 (
      .old_i  (old1),
      .new_i  (write_data_1),
      .be_i   (byte_enable_1),
      .word_o (wword1)
   );

   assign base0 = (wr1 && same_addr) ? wword1 : old0;

   se_sram_lane_merge #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .BE_W(BE_W)) u_merge0 (
      .old_i  (base0),
      .new_i  (write_data_0),
      .be_i   (byte_enable_0),
      .word_o (wword0)
   );

   // A read sees the word as it stands after this cycle's writes (write-first).
   // base0 is exactly that for port 0; port 1 picks up port 0's merged word.
   assign rdata1 = (wr0 && same_addr) ? wword0 : old1;

   // Both ports in one block: on a same-address double write the port 0
   // assignment comes last and carries port 1's lanes already merged in.
   always_ff @(posedge sram_clock) begin
      if (clear_we) begin
         mem_q[clr_addr_q] <= '0;
      end else begin
         if (wr1) mem_q[address_1] <= wword1;
         if (wr0) mem_q[address_0] <= wword0;
      end
   end

   // Init FSM; busy_q is its registered output and is high exactly in CLEAR.
   always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
         state_q    <= CLEAR_ON_RESET ? INIT_CLEAR : INIT_IDLE;
         busy_q     <= CLEAR_ON_RESET;
         clr_addr_q <= '0;
      end else if (sram_clock__enable) begin
         case (state_q)
            INIT_IDLE: begin
               busy_q <= 1'b0;
            end
            INIT_CLEAR: begin
               if (&clr_addr_q) begin
                  state_q <= INIT_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + 1'b1;
               end
            end
            default: begin
               state_q <= INIT_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign init_busy = busy_q;

   // Read pipes
   logic [1:0]        rd_acc;
   logic [DATA_W-1:0] rd_word [2];
   logic [DATA_W-1:0] dout    [2];
   logic [1:0]        dvld;

   assign rd_acc     = {rd1, rd0};
   assign rd_word[0] = base0;
   assign rd_word[1] = rdata1;

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic              src_vld;
      logic [DATA_W-1:0] src_dat;
      logic              vld_q;
      logic [DATA_W-1:0] dat_q;

      if (READ_LATENCY == 2) begin : g_lat2
         logic              stg_vld_q;
         logic [DATA_W-1:0] stg_dat_q;

         always_ff @(posedge sram_clock) begin
            if (sram_reset) begin
               stg_vld_q <= 1'b0;
               stg_dat_q <= '0;
            end else if (sram_clock__enable) begin
               stg_vld_q <= rd_acc[p];
               if (rd_acc[p]) stg_dat_q <= rd_word[p];
            end
         end

         assign src_vld = stg_vld_q;
         assign src_dat = stg_dat_q;
      end else begin : g_lat1
         assign src_vld = rd_acc[p];
         assign src_dat = rd_word[p];
      end

      // The valid flag is a pulse, not pipeline state: it is dropped during a
      // stall so each read produces exactly one high cycle. Data holds.
      always_ff @(posedge sram_clock) begin
         if (sram_reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
         end else if (sram_clock__enable) begin
            vld_q <= src_vld;
            if (src_vld) dat_q <= src_dat;
         end else begin
            vld_q <= 1'b0;
         end
      end

      assign dout[p] = dat_q;
      assign dvld[p] = vld_q;
   end

   assign data_out_0   = dout[0];
   assign data_out_1   = dout[1];
   assign data_valid_0 = dvld[0];
   assign data_valid_1 = dvld[1];

endmodule

// File: tb/tb_se_sram_tdp_be.sv
// Bench for se_sram_tdp_be: latency-1 and latency-2 instances share one stimulus stream;
// a word-level memory model feeds per-instance/per-port expectation queues drained by a monitor.
// Latency/backpressure: expectations carry the enabled-edge count at which data must appear.
module tb_se_sram_tdp_be;

   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] dat;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, en;
   logic [1:0]       sel, rnw;
   logic [1:0][3:0]  be;
   logic [1:0][3:0]  addr;
   logic [1:0][31:0] wd;

   wire [1:0][1:0][31:0] dout;
   wire [1:0][1:0]       dvld;
   wire [1:0]            busy;

   se_sram_tdp_be #(.ADDR_W(4), .DATA_W(32), .BYTE_W(8), .READ_LATENCY(1),
                    .CLEAR_ON_RESET(1'b1), .INITFILE("")) u_lat1 (
      .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en),
      .select_0(sel[0]), .read_not_write_0(rnw[0]), .byte_enable_0(be[0]),
      .address_0(addr[0]), .write_data_0(wd[0]),
      .data_out_0(dout[0][0]), .data_valid_0(dvld[0][0]),
      .select_1(sel[1]), .read_not_write_1(rnw[1]), .byte_enable_1(be[1]),
      .address_1(addr[1]), .write_data_1(wd[1]),
      .data_out_1(dout[0][1]), .data_valid_1(dvld[0][1]),
      .init_busy(busy[0])
   );

   se_sram_tdp_be #(.ADDR_W(4), .DATA_W(32), .BYTE_W(8), .READ_LATENCY(2),
                    .CLEAR_ON_RESET(1'b1), .INITFILE("")) u_lat2 (
      .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en),
      .select_0(sel[0]), .read_not_write_0(rnw[0]), .byte_enable_0(be[0]),
      .address_0(addr[0]), .write_data_0(wd[0]),
      .data_out_0(dout[1][0]), .data_valid_0(dvld[1][0]),
      .select_1(sel[1]), .read_not_write_1(rnw[1]), .byte_enable_1(be[1]),
      .address_1(addr[1]), .write_data_1(wd[1]),
      .data_out_1(dout[1][1]), .data_valid_1(dvld[1][1]),
      .init_busy(busy[1])
   );

   // Reference state
   exp_t        sb_q [2][2][$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] last_out [2][2];
   int          sweep;
   int          en_edges;
   bit          started;
   int          n_checks;
   int          n_pass;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_checks++;
      if (got === exp_v) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp_v, $time);
   endtask

   // Apply one clock edge to the model using the inputs the bench is driving.
   task automatic model_edge();
      logic [31:0] w;
      if (rst) begin
         started = 1'b1;
         sweep   = DEPTH;
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               sb_q[d][p].delete();
               last_out[d][p] = '0;
            end
         end
      end else if (en) begin
         en_edges++;
         if (sweep > 0) begin
            ref_mem[DEPTH - sweep] = '0;
            sweep--;
         end else begin
            // Port 1 lanes first, then port 0 lanes on top: port 0 wins shared lanes.
            for (int p = 1; p >= 0; p--) begin
               if (sel[p] && !rnw[p]) begin
                  w = ref_mem[addr[p]];
                  for (int k = 0; k < 4; k++) begin
                     if (be[p][k]) w[8*k +: 8] = wd[p][8*k +: 8];
                  end
                  ref_mem[addr[p]] = w;
               end
            end
            // Reads return the word as it stands after this edge's writes.
            for (int p = 0; p < 2; p++) begin
               if (sel[p] && rnw[p]) begin
                  for (int d = 0; d < 2; d++) begin
                     sb_q[d][p].push_back('{dat: ref_mem[addr[p]], due: en_edges + d});
                  end
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rst  = 1'b0;
      en   = 1'b1;
      sel  = '0;
      rnw  = '0;
      be   = '0;
      addr = '0;
      wd   = '0;
   endtask

   task automatic set_req(input int p, input bit r, input logic [3:0] b,
                          input logic [3:0] a, input logic [31:0] d);
      sel[p]  = 1'b1;
      rnw[p]  = r;
      be[p]   = b;
      addr[p] = a;
      wd[p]   = d;
   endtask

   // Monitor: decoupled from stimulus, samples on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (dvld[d][p]) begin
                  if (sb_q[d][p].size() == 0) begin
                     check($sformatf("valid_without_read lat%0d p%0d", d + 1, p),
                           {31'b0, dvld[d][p]}, 32'd0);
                  end else begin
                     e = sb_q[d][p].pop_front();
                     check($sformatf("rd_data lat%0d p%0d", d + 1, p), dout[d][p], e.dat);
                     check($sformatf("rd_edge lat%0d p%0d", d + 1, p), 32'(en_edges), 32'(e.due));
                     last_out[d][p] = e.dat;
                  end
               end else begin
                  check($sformatf("dout_hold lat%0d p%0d", d + 1, p), dout[d][p], last_out[d][p]);
               end
            end
            check($sformatf("init_busy lat%0d", d + 1), {31'b0, busy[d]}, {31'b0, (sweep > 0)});
         end
      end
   end

   initial begin
      logic [3:0] a0;
      n_checks = 0;
      n_pass   = 0;
      en_edges = 0;
      sweep    = 0;
      started  = 1'b0;
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Clear sweep; requests during the sweep must be ignored.
      repeat (3) step();
      set_req(0, 1'b0, 4'hF, 4'd2, 32'hFFFF_FFFF);
      set_req(1, 1'b1, 4'h0, 4'd3, 32'h0);
      step();
      idle();
      repeat (16) step();
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         set_req(0, 1'b1, 4'h0, 4'(a), 32'h0);
         step();
      end

      // Partial-lane overwrite.
      idle(); set_req(0, 1'b0, 4'b1111, 4'd5, 32'hDEAD_BEEF); step();
      idle(); set_req(0, 1'b0, 4'b0101, 4'd5, 32'h1122_3344); step();
      idle(); set_req(0, 1'b1, 4'h0, 4'd5, 32'h0); step();

      // Same-cycle write/write with overlapping lanes.
      idle(); set_req(1, 1'b0, 4'hF, 4'd3, 32'h9988_7766); step();
      idle();
      set_req(0, 1'b0, 4'b0011, 4'd3, 32'hAAAA_AAAA);
      set_req(1, 1'b0, 4'b0110, 4'd3, 32'hBBBB_BBBB);
      step();
      idle(); set_req(1, 1'b1, 4'h0, 4'd3, 32'h0); step();

      // Same-cycle write on port 0 / read on port 1.
      idle();
      set_req(0, 1'b0, 4'b1000, 4'd7, 32'h1234_5678);
      set_req(1, 1'b1, 4'h0, 4'd7, 32'h0);
      step();

      // Read stream with enable dropped for two cycles.
      idle(); set_req(0, 1'b1, 4'h0, 4'd1, 32'h0); step();
      idle(); set_req(0, 1'b1, 4'h0, 4'd2, 32'h0); step();
      idle(); set_req(0, 1'b1, 4'h0, 4'd3, 32'h0); en = 1'b0; step(); step();
      en = 1'b1; step();
      idle(); repeat (4) step();

      // Reset mid-sweep (next sweep address 9) restarts the sweep.
      rst = 1'b1; step(); rst = 1'b0;
      repeat (9) step();
      rst = 1'b1; step(); rst = 1'b0;
      repeat (5) step();
      set_req(1, 1'b1, 4'h0, 4'd4, 32'h0); step();
      idle(); repeat (14) step();

      // Randomised traffic with collisions, stalls and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         idle();
         en  = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 299) == 0);
         a0  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) != 0)
            set_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a0, $urandom());
         if ($urandom_range(0, 2) != 0)
            set_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) != 0) ? a0 : 4'($urandom_range(0, 15)), $urandom());
         step();
      end

      idle();
      repeat (6) step();
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            check($sformatf("pending_reads lat%0d p%0d", d + 1, p), 32'(sb_q[d][p].size()), 32'd0);
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
